// File: rtl/fast_frame_sched.sv
// Frame sequencer for the FAST corner pipeline: raster tracking, border gating,
// (x,y) tagging across the detector latency, and a capped corner FIFO.
module fast_frame_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int FAST_LAT    = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_CORNERS = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_start,
    input  logic [DATA_WIDTH-1:0]              threshold_cfg,
    input  logic                               win_valid,
    output logic                               fast_win_valid,
    output logic [DATA_WIDTH-1:0]              fast_threshold,
    input  logic                               fast_out_valid,
    input  logic                               fast_is_corner,
    input  logic [DATA_WIDTH-1:0]              fast_score,
    output logic                               corner_valid,
    input  logic                               corner_ready,
    output logic [$clog2(IMG_W)-1:0]           corner_x,
    output logic [$clog2(IMG_H)-1:0]           corner_y,
    output logic [DATA_WIDTH-1:0]              corner_score,
    output logic                               busy,
    output logic                               frame_done,
    output logic [$clog2(MAX_CORNERS+1)-1:0]   corner_count,
    output logic [15:0]                        drop_count,
    output logic                               err_sync
);
    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int CNT_W = $clog2(MAX_CORNERS+1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LAT_W = $clog2(FAST_LAT+1);
    localparam int ENT_W = X_W + Y_W + DATA_WIDTH;

    localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_W-1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(IMG_H-1);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(MAX_CORNERS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [DATA_WIDTH-1:0]   thr_q, thr_d;
    logic [LAT_W-1:0]        drain_q, drain_d;
    logic                    clr_cnt;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        thr_d   = thr_q;
        drain_d = drain_q;
        clr_cnt = 1'b0;
        case (state_q)
            IDLE: if (frame_start) begin
                state_d = RUN;
                thr_d   = threshold_cfg;
                x_d     = '0;
                y_d     = '0;
                clr_cnt = 1'b1;
            end
            RUN: if (win_valid) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            // Hold off DONE until the last issued window has left the tag pipe.
            DRAIN: if (drain_q == LAT_W'(FAST_LAT-1)) state_d = DONE;
                   else drain_d = drain_q + 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            thr_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            thr_q   <= thr_d;
            drain_q <= drain_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);
    assign fast_threshold = thr_q;
    assign fast_win_valid = win_valid && (state_q == RUN)
                         && (x_q >= X_W'(3)) && (x_q <= X_W'(IMG_W-4))
                         && (y_q >= Y_W'(3)) && (y_q <= Y_W'(IMG_H-4));

    // Tag pipe: stage FAST_LAT lines up with the detector's out_valid.
    logic [FAST_LAT:1]            vld_pipe_q;
    logic [FAST_LAT:1][X_W-1:0]   tag_x_q;
    logic [FAST_LAT:1][Y_W-1:0]   tag_y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            tag_x_q    <= '0;
            tag_y_q    <= '0;
        end else begin
            vld_pipe_q[1] <= fast_win_valid;
            tag_x_q[1]    <= x_q;
            tag_y_q[1]    <= y_q;
            for (int i = 2; i <= FAST_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                tag_x_q[i]    <= tag_x_q[i-1];
                tag_y_q[i]    <= tag_y_q[i-1];
            end
        end
    end

    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [PTR_W:0]    fcnt_q;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]  ccnt_q;
    logic [15:0]       dcnt_q;
    logic              err_q;
    logic              push_cand, cap_hit, fifo_full, push, drop, pop;

    assign push_cand = fast_out_valid && fast_is_corner && vld_pipe_q[FAST_LAT];
    assign cap_hit   = (ccnt_q == CAP);
    assign fifo_full = (fcnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign push      = push_cand && !cap_hit && !fifo_full;
    assign drop      = push_cand && (cap_hit || fifo_full);
    assign pop       = corner_valid && corner_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {tag_x_q[FAST_LAT], tag_y_q[FAST_LAT], fast_score};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            ccnt_q <= '0;
            dcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
            if (clr_cnt) begin
                ccnt_q <= '0;
                dcnt_q <= '0;
            end else begin
                if (push) ccnt_q <= ccnt_q + 1'b1;
                if (drop && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 1'b1;
            end
            if (fast_out_valid != vld_pipe_q[FAST_LAT]) err_q <= 1'b1;
        end
    end

    assign corner_valid = (fcnt_q != '0);
    assign {corner_x, corner_y, corner_score} = corner_valid ? mem_q[rd_q] : '0;
    assign corner_count = ccnt_q;
    assign drop_count   = dcnt_q;
    assign err_sync     = err_q;

endmodule

// File: tb/tb_fast_frame_sched.sv
// Directed bench for fast_frame_sched on a 16x12 frame with a behavioural
// FAST detector whose latency can be switched to provoke a sync error.
module tb_fast_frame_sched;
    localparam int W = 16;
    localparam int H = 12;

    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, win_valid = 1'b0;
    logic        corner_ready = 1'b0;
    logic [7:0]  threshold_cfg = 8'h00;
    logic        fast_win_valid, fast_out_valid, fast_is_corner;
    logic [7:0]  fast_threshold, fast_score, corner_score;
    logic        corner_valid, busy, frame_done, err_sync;
    logic [3:0]  corner_x, corner_y;
    logic [2:0]  corner_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    fast_frame_sched #(
        .DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .FAST_LAT(4),
        .FIFO_DEPTH(4), .MAX_CORNERS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .threshold_cfg(threshold_cfg), .win_valid(win_valid),
        .fast_win_valid(fast_win_valid), .fast_threshold(fast_threshold),
        .fast_out_valid(fast_out_valid), .fast_is_corner(fast_is_corner),
        .fast_score(fast_score), .corner_valid(corner_valid),
        .corner_ready(corner_ready), .corner_x(corner_x), .corner_y(corner_y),
        .corner_score(corner_score), .busy(busy), .frame_done(frame_done),
        .corner_count(corner_count), .drop_count(drop_count), .err_sync(err_sync)
    );

    // Detector model: score map per pixel (0 = no corner), delayed by lat_sel+1 cycles.
    int          px = 0, py = 0;
    logic [2:0]  lat_sel = 3'd3;
    logic [7:0]  smap [0:W*H-1];
    logic [7:0]  pix_idx, cur_score;
    logic [7:0]  mv, mc;
    logic [7:0]  ms [0:7];

    assign pix_idx        = 8'(py*W + px);
    assign cur_score      = smap[pix_idx];
    assign fast_out_valid = mv[lat_sel];
    assign fast_is_corner = mv[lat_sel] & mc[lat_sel];
    assign fast_score     = ms[lat_sel];

    always @(posedge clk) begin
        if (!rst_n) begin
            mv <= '0;
            mc <= '0;
        end else begin
            mv <= {mv[6:0], fast_win_valid};
            mc <= {mc[6:0], fast_win_valid && (cur_score != 8'h00)};
        end
        ms[0] <= cur_score;
        for (int i = 1; i < 8; i++) ms[i] <= ms[i-1];
    end

    int          fwv_n = 0, done_n = 0;
    logic [15:0] popq [$];

    always @(posedge clk) begin
        if (fast_win_valid) fwv_n <= fwv_n + 1;
        if (frame_done)     done_n <= done_n + 1;
        if (rst_n && corner_valid && corner_ready)
            popq.push_back({corner_x, corner_y, corner_score});
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < W*H; i++) smap[i] = 8'h00;
    endtask

    // Full frame; frame_start is re-pulsed at pixel ignore_at (use -1 for none).
    task automatic run_frame(input logic [7:0] thr, input int ignore_at);
        frame_start = 1'b1;
        threshold_cfg = thr;
        tick();
        frame_start = 1'b0;
        threshold_cfg = 8'hEE;
        for (int i = 0; i < W*H; i++) begin
            px = i % W;
            py = i / W;
            win_valid = 1'b1;
            frame_start = (i == ignore_at);
            tick();
            if (i == 100) chk("thr_held", 32'(fast_threshold), 32'(thr));
        end
        win_valid = 1'b0;
        frame_start = 1'b0;
        px = 0;
        py = 0;
        repeat (8) tick();
    endtask

    int f0, d0, q0;

    initial begin
        clear_map();
        repeat (3) tick();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_cvalid", 32'(corner_valid), 0);
        chk("rst_ccount", 32'(corner_count), 0);
        chk("rst_drop",   32'(drop_count), 0);
        chk("rst_err",    32'(err_sync), 0);
        chk("rst_thr",    32'(fast_threshold), 0);
        chk("rst_done",   32'(frame_done), 0);
        chk("rst_fwv",    32'(fast_win_valid), 0);
        rst_n = 1'b1;
        tick();

        // Empty frame: 10x6 legal centres, one frame_done.
        corner_ready = 1'b1;
        f0 = fwv_n; d0 = done_n; q0 = popq.size();
        run_frame(8'h15, -1);
        chk("a_fwv",    32'(fwv_n - f0), 60);
        chk("a_done",   32'(done_n - d0), 1);
        chk("a_ccount", 32'(corner_count), 0);
        chk("a_drop",   32'(drop_count), 0);
        chk("a_err",    32'(err_sync), 0);
        chk("a_busy",   32'(busy), 0);
        chk("a_pops",   32'(popq.size() - q0), 0);

        // Single corner at (5,4).
        smap[4*W+5] = 8'h2A;
        q0 = popq.size();
        run_frame(8'h20, -1);
        chk("b_pops",   32'(popq.size() - q0), 1);
        chk("b_entry",  32'(popq[q0]), 32'h542A);
        chk("b_ccount", 32'(corner_count), 1);
        chk("b_drop",   32'(drop_count), 0);
        chk("b_cvalid", 32'(corner_valid), 0);

        // Six corners into a 4-deep FIFO with the consumer stalled.
        clear_map();
        for (int k = 0; k < 6; k++) smap[3*W+3+k] = 8'(k+1);
        corner_ready = 1'b0;
        run_frame(8'h30, -1);
        chk("c_ccount", 32'(corner_count), 4);
        chk("c_drop",   32'(drop_count), 2);
        chk("c_cvalid", 32'(corner_valid), 1);
        chk("c_headx",  32'(corner_x), 3);
        q0 = popq.size();
        corner_ready = 1'b1;
        repeat (8) tick();
        chk("c_pops", 32'(popq.size() - q0), 4);
        for (int k = 0; k < 4; k++)
            chk("c_order", 32'(popq[q0+k]), 32'({4'(3+k), 4'd3, 8'(k+1)}));
        chk("c_empty",  32'(corner_valid), 0);
        chk("c_hold",   32'(corner_count), 4);

        // Seven corners against a cap of five.
        clear_map();
        for (int k = 0; k < 7; k++) smap[5*W+3+k] = 8'(8'h40 + k);
        q0 = popq.size();
        run_frame(8'h40, -1);
        chk("d_ccount", 32'(corner_count), 5);
        chk("d_drop",   32'(drop_count), 2);
        chk("d_pops",   32'(popq.size() - q0), 5);
        chk("d_last",   32'(popq[popq.size()-1]), 32'h7544);

        // frame_start mid-RUN must not restart the raster.
        clear_map();
        f0 = fwv_n; d0 = done_n;
        run_frame(8'h55, 20);
        chk("e_fwv",  32'(fwv_n - f0), 60);
        chk("e_done", 32'(done_n - d0), 1);
        chk("e_busy", 32'(busy), 0);

        // Detector one cycle early.
        lat_sel = 3'd2;
        run_frame(8'h66, -1);
        chk("f_err", 32'(err_sync), 1);
        lat_sel = 3'd3;

        // Reset in the middle of RUN with two corners queued.
        corner_ready = 1'b0;
        clear_map();
        smap[3*W+3] = 8'h01;
        smap[3*W+4] = 8'h02;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            px = i % W;
            py = i / W;
            win_valid = 1'b1;
            tick();
        end
        win_valid = 1'b0;
        px = 0;
        py = 0;
        chk("g_busy_pre",   32'(busy), 1);
        chk("g_cvalid_pre", 32'(corner_valid), 1);
        chk("g_ccount_pre", 32'(corner_count), 2);
        chk("g_err_sticky", 32'(err_sync), 1);
        rst_n = 1'b0;
        tick();
        chk("g_busy",   32'(busy), 0);
        chk("g_cvalid", 32'(corner_valid), 0);
        chk("g_ccount", 32'(corner_count), 0);
        chk("g_drop",   32'(drop_count), 0);
        chk("g_err",    32'(err_sync), 0);
        rst_n = 1'b1;
        tick();
        chk("g_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
